// File: rtl/stage4_pow2_sum_buffer.sv
// Softmax stage 4: buffers one vector of pow2 values, accumulates their exact sum,
// then replays every element alongside the frozen sum for the divide stage.
module stage4_pow2_sum_buffer #(
    parameter int VEC_LEN = 64,
    parameter int DATA_W  = 16,
    localparam int SUM_W  = DATA_W + $clog2(VEC_LEN)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_pow_x,
    input  logic [DATA_W-1:0] i_x_byp,
    output logic              o_ready,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_pow_x,
    output logic [DATA_W-1:0] o_x_byp,
    output logic [SUM_W-1:0]  o_sum,
    output logic              o_last,
    output logic              o_drop
);

    localparam int IDX_W = $clog2(VEC_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_LEN - 1);

    localparam logic [1:0] ST_ACCUM = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]          r_state;
    logic [IDX_W-1:0]    r_wr_cnt;
    logic [IDX_W-1:0]    r_rd_cnt;
    logic [SUM_W-1:0]    r_sum;
    logic                r_ready;
    logic                r_valid;
    logic                r_last;
    logic                r_drop;
    logic [DATA_W-1:0]   r_pow_x;
    logic [DATA_W-1:0]   r_x_byp;
    logic [SUM_W-1:0]    r_out_sum;
    logic [2*DATA_W-1:0] r_buf [VEC_LEN];

    logic                w_accept;
    logic                w_drop;
    logic [2*DATA_W-1:0] w_rd_data;
    logic [SUM_W-1:0]    w_pow_ext;

    // Handshake decode and the single buffer read port (rd_cnt is 0 in LOAD).
    always_comb begin
        w_accept  = i_en & i_valid & r_ready;
        w_drop    = i_en & i_valid & ~r_ready;
        w_rd_data = r_buf[r_rd_cnt];
        w_pow_ext = {{(SUM_W-DATA_W){1'b0}}, i_pow_x};
    end

    // Vector buffer, written at the accept edge; no reset so it can map to RAM.
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_buf[r_wr_cnt] <= {i_pow_x, i_x_byp};
        end
    end

    // Control FSM, accumulator and output register set; everything holds while i_en=0.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_ACCUM;
            r_wr_cnt  <= '0;
            r_rd_cnt  <= '0;
            r_sum     <= '0;
            r_ready   <= 1'b1;
            r_valid   <= 1'b0;
            r_last    <= 1'b0;
            r_pow_x   <= '0;
            r_x_byp   <= '0;
            r_out_sum <= '0;
        end else if (i_en) begin
            case (r_state)
                ST_ACCUM: begin
                    if (w_accept) begin
                        r_sum    <= r_sum + w_pow_ext;
                        r_wr_cnt <= r_wr_cnt + IDX_W'(1);
                        if (r_wr_cnt == LAST_IDX) begin
                            r_state <= ST_LOAD;
                            r_ready <= 1'b0;
                        end
                    end
                end
                ST_LOAD: begin
                    r_pow_x   <= w_rd_data[2*DATA_W-1:DATA_W];
                    r_x_byp   <= w_rd_data[DATA_W-1:0];
                    r_out_sum <= r_sum;
                    r_sum     <= '0;
                    r_rd_cnt  <= IDX_W'(1);
                    r_valid   <= 1'b1;
                    r_last    <= 1'b0;
                    r_state   <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    // The final handshake returns to ACCUM; input opens only from the next cycle.
                    if (r_valid && i_ready) begin
                        if (r_last) begin
                            r_valid  <= 1'b0;
                            r_last   <= 1'b0;
                            r_rd_cnt <= '0;
                            r_ready  <= 1'b1;
                            r_state  <= ST_ACCUM;
                        end else begin
                            r_pow_x  <= w_rd_data[2*DATA_W-1:DATA_W];
                            r_x_byp  <= w_rd_data[DATA_W-1:0];
                            r_last   <= (r_rd_cnt == LAST_IDX);
                            r_rd_cnt <= r_rd_cnt + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    r_state  <= ST_ACCUM;
                    r_wr_cnt <= '0;
                    r_rd_cnt <= '0;
                    r_sum    <= '0;
                    r_ready  <= 1'b1;
                    r_valid  <= 1'b0;
                    r_last   <= 1'b0;
                end
            endcase
        end
    end

    // Drop flag: one-cycle pulse for a sample offered while the buffer is busy.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_drop <= 1'b0;
        end else begin
            r_drop <= w_drop;
        end
    end

    assign o_ready = r_ready;
    assign o_valid = r_valid;
    assign o_pow_x = r_pow_x;
    assign o_x_byp = r_x_byp;
    assign o_sum   = r_out_sum;
    assign o_last  = r_last;
    assign o_drop  = r_drop;

endmodule

// File: tb/tb_stage4_pow2_sum_buffer.sv
// Scoreboard bench for stage4_pow2_sum_buffer (VEC_LEN=4 main instance, VEC_LEN=64 max-sum instance).
module tb_stage4_pow2_sum_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_en, i_valid, i_ready;
    logic [15:0] i_pow_x, i_x_byp;
    logic        o_ready, o_valid, o_last, o_drop;
    logic [15:0] o_pow_x, o_x_byp;
    logic [17:0] o_sum;

    logic        en64, valid64, ready64;
    logic [15:0] pow64, x64;
    logic        o_ready64, o_valid64, o_last64, o_drop64;
    logic [15:0] o_pow64, o_x64;
    logic [21:0] o_sum64;

    typedef struct packed {
        logic [15:0] p;
        logic [15:0] x;
        logic [17:0] s;
        logic        l;
    } exp_t;

    exp_t        sb[$];
    exp_t        em;
    int          n_checks = 0;
    int          n_fail = 0;
    logic        rdy_toggle = 1'b0;
    logic        hold_prev = 1'b0;
    logic        ready_due = 1'b0;
    logic [50:0] prev_out;
    logic [15:0] vp[4];
    logic [15:0] vx[4];

    always #5 clk = ~clk;

    stage4_pow2_sum_buffer #(.VEC_LEN(4), .DATA_W(16)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(i_en), .i_valid(i_valid),
        .i_pow_x(i_pow_x), .i_x_byp(i_x_byp), .o_ready(o_ready), .o_valid(o_valid),
        .i_ready(i_ready), .o_pow_x(o_pow_x), .o_x_byp(o_x_byp), .o_sum(o_sum),
        .o_last(o_last), .o_drop(o_drop)
    );

    stage4_pow2_sum_buffer #(.VEC_LEN(64), .DATA_W(16)) u_dut64 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en64), .i_valid(valid64),
        .i_pow_x(pow64), .i_x_byp(x64), .o_ready(o_ready64), .o_valid(o_valid64),
        .i_ready(ready64), .o_pow_x(o_pow64), .o_x_byp(o_x64), .o_sum(o_sum64),
        .o_last(o_last64), .o_drop(o_drop64)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Downstream ready: constant 1 or toggling every cycle.
    initial begin
        i_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_toggle) i_ready = ~i_ready;
            else i_ready = 1'b1;
        end
    end

    // Output monitor: scoreboard pops on handshakes, stability under stall, o_ready during drain.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ready_due) begin
                check_val("ready_after_last", {62'd0, o_ready, o_valid}, 64'h2);
                ready_due = 1'b0;
            end
            if (hold_prev) begin
                check_val("hold_stable", {13'd0, o_valid, o_pow_x, o_x_byp, o_sum, o_last}, {13'd0, 1'b1, prev_out});
            end
            if (o_valid) begin
                check_val("ready_low_in_drain", {63'd0, o_ready}, 64'd0);
            end
            if (o_valid && i_ready && i_en) begin
                if (sb.size() == 0) begin
                    check_val("unexpected_out", 64'd1, 64'd0);
                end else begin
                    em = sb.pop_front();
                    check_val("out_pow_x", {48'd0, o_pow_x}, {48'd0, em.p});
                    check_val("out_x_byp", {48'd0, o_x_byp}, {48'd0, em.x});
                    check_val("out_sum",   {46'd0, o_sum},   {46'd0, em.s});
                    check_val("out_last",  {63'd0, o_last},  {63'd0, em.l});
                    if (em.l) ready_due = 1'b1;
                end
            end
            hold_prev = o_valid && !(i_ready && i_en);
            prev_out  = {o_pow_x, o_x_byp, o_sum, o_last};
        end else begin
            hold_prev = 1'b0;
            ready_due = 1'b0;
        end
    end

    task automatic send_vector(input int freeze_at);
        exp_t        e;
        logic [17:0] s;
        int          t;
        s = 18'd0;
        for (int i = 0; i < 4; i++) s = s + {2'b00, vp[i]};
        for (int i = 0; i < 4; i++) begin
            e.p = vp[i];
            e.x = vx[i];
            e.s = s;
            e.l = (i == 3);
            sb.push_back(e);
        end
        t = 0;
        while (!o_ready && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        check_val("ready_before_send", {63'd0, o_ready}, 64'd1);
        for (int i = 0; i < 4; i++) begin
            if (i == freeze_at) begin
                // Offered but frozen: must neither be accepted nor flagged as dropped.
                i_en = 1'b0;
                i_valid = 1'b1;
                i_pow_x = 16'hDEAD;
                repeat (5) begin
                    @(posedge clk);
                    #1;
                end
                check_val("no_drop_when_frozen", {63'd0, o_drop}, 64'd0);
                i_en = 1'b1;
            end
            i_valid = 1'b1;
            i_pow_x = vp[i];
            i_x_byp = vx[i];
            @(posedge clk);
            #1;
        end
        i_valid = 1'b0;
    endtask

    task automatic wait_drained();
        int t;
        t = 0;
        while ((sb.size() != 0 || !o_ready) && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        check_val("drain_done", {32'd0, sb.size()}, 64'd0);
    endtask

    task automatic load_vec(input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] c, input logic [15:0] d);
        vp[0] = a; vp[1] = b; vp[2] = c; vp[3] = d;
        for (int i = 0; i < 4; i++) vx[i] = 16'h0400 + 16'(i * 16'h0111);
    endtask

    initial begin
        int t;
        int cnt;
        rst_n = 1'b0; i_en = 1'b1; i_valid = 1'b0; i_pow_x = 16'd0; i_x_byp = 16'd0;
        en64 = 1'b1; valid64 = 1'b0; ready64 = 1'b1; pow64 = 16'd0; x64 = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_ready", {63'd0, o_ready}, 64'd1);
        check_val("rst_valid_last_drop", {61'd0, o_valid, o_last, o_drop}, 64'd0);
        check_val("rst_data", {30'd0, o_pow_x, o_x_byp, o_sum}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: basic vector, latency check.
        load_vec(16'h8000, 16'h4000, 16'h2000, 16'h1000);
        send_vector(-1);
        check_val("lat_valid_low", {62'd0, o_valid, o_ready}, 64'd0);
        @(posedge clk);
        #1;
        check_val("lat_valid_high", {63'd0, o_valid}, 64'd1);
        check_val("lat_sum", {46'd0, o_sum}, 64'h0F000);
        wait_drained();

        // 2: backpressure toggling.
        rdy_toggle = 1'b1;
        send_vector(-1);
        wait_drained();
        rdy_toggle = 1'b0;
        @(posedge clk);
        #1;

        // 3a: max values, no wrap.
        load_vec(16'hFFE0, 16'hFFE0, 16'hFFE0, 16'hFFE0);
        send_vector(-1);
        @(posedge clk);
        #1;
        check_val("max_sum4", {46'd0, o_sum}, 64'h3FF80);
        wait_drained();

        // 4: sample offered during drain is dropped and excluded.
        load_vec(16'h0010, 16'h0020, 16'h0030, 16'h0040);
        send_vector(-1);
        @(posedge clk);
        #1;
        i_valid = 1'b1;
        i_pow_x = 16'h1234;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        check_val("drop_pulse", {63'd0, o_drop}, 64'd1);
        @(posedge clk);
        #1;
        check_val("drop_cleared", {63'd0, o_drop}, 64'd0);
        wait_drained();
        load_vec(16'h0001, 16'h0002, 16'h0003, 16'h0004);
        send_vector(-1);
        @(posedge clk);
        #1;
        check_val("sum_excludes_drop", {46'd0, o_sum}, 64'd10);
        wait_drained();

        // 5: freeze mid-ACCUM then mid-DRAIN; results match test 1.
        load_vec(16'h8000, 16'h4000, 16'h2000, 16'h1000);
        send_vector(2);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        i_en = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        check_val("frozen_valid", {63'd0, o_valid}, 64'd1);
        i_en = 1'b1;
        wait_drained();

        // 6: reset after a partial vector, then a clean vector 1,2,3,4.
        i_valid = 1'b1; i_pow_x = 16'h7777; i_x_byp = 16'h0001;
        @(posedge clk);
        #1;
        i_pow_x = 16'h6666;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        check_val("rst2_state", {62'd0, o_ready, o_valid}, 64'h2);
        check_val("rst2_sum", {46'd0, o_sum}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        load_vec(16'd1, 16'd2, 16'd3, 16'd4);
        send_vector(-1);
        @(posedge clk);
        #1;
        check_val("post_rst_sum", {46'd0, o_sum}, 64'd10);
        wait_drained();

        // 3b: VEC_LEN=64, all 0xFFFF.
        for (int i = 0; i < 64; i++) begin
            valid64 = 1'b1;
            pow64 = 16'hFFFF;
            x64 = 16'(i);
            @(posedge clk);
            #1;
        end
        valid64 = 1'b0;
        cnt = 0;
        t = 0;
        while (cnt < 64 && t < 300) begin
            @(negedge clk);
            t++;
            if (o_valid64) begin
                check_val("v64_sum", {42'd0, o_sum64}, 64'h3FFFC0);
                check_val("v64_x", {48'd0, o_x64}, 64'(cnt));
                check_val("v64_last", {63'd0, o_last64}, {63'd0, (cnt == 63)});
                cnt++;
            end
        end
        check_val("v64_count", 64'(cnt), 64'd64);
        repeat (3) @(posedge clk);
        #1;
        check_val("v64_idle", {62'd0, o_ready64, o_valid64}, 64'h2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
